i3c_transfer_sequencer: RTL and testbench

Upstream command sequencer for the I3C master output-control PHY. It accepts a transfer command (address, direction, byte count, stop/hold) plus byte streams for write and read data. It breaks each transfer into single PHY primitives (start or repeated start, header, ACK sample, data words, stop) and issues them one at a time as 1-cycle pulses, waiting for PHY completion between them. It reports per-transfer status to the register/CSR layer.

---
 rtl/i3c_transfer_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_i3c_transfer_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i3c_transfer_sequencer.sv
// I3C transfer sequencer: breaks a transfer command into single PHY primitives
// (start, header, ACK, data, stop), issuing one pulse at a time and waiting for PHY completion.
module i3c_transfer_sequencer #(
  parameter int ISSUE_GAP = 4,
  parameter int LEN_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [6:0]       cmd_addr,
  input  logic             cmd_rnw,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_stop,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             done_valid,
  output logic             done_nack,
  output logic             done_early,
  output logic [LEN_W-1:0] done_count,
  output logic             busy,
  output logic             phy_start,
  output logic             phy_repeated_start,
  output logic             phy_stop,
  output logic             phy_datatx,
  output logic             phy_datarx,
  output logic             phy_acknack_noh,
  output logic [8:0]       phy_data_in,
  output logic             phy_data_in_last,
  input  logic             phy_busy,
  input  logic [8:0]       phy_data_out,
  input  logic             phy_acknack_rcvd
);
  typedef enum logic [3:0] {IDLE, START, HDR, ACK, WR, RD, RD_HOLD, STOP, DONE, WAIT} state_t;
  localparam int GAP_W = $clog2(ISSUE_GAP + 1);

  state_t           state_q, state_d, prim_q, prim_d, fin;
  logic [6:0]       addr_q, addr_d;
  logic             rnw_q, rnw_d, stop_q, stop_d, bus_held_q, bus_held_d;
  logic [LEN_W-1:0] len_q, len_d, count_q, count_d, cnt_inc;
  logic             seen_q, seen_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             nack_q, nack_d, early_q, early_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d, tx_ready_q, tx_ready_d;
  logic             cmd_ready_q, cmd_ready_d, busy_q, busy_d, done_valid_q, done_valid_d;
  logic             start_q, start_d, rstart_q, rstart_d, pstop_q, pstop_d;
  logic             datatx_q, datatx_d, datarx_q, datarx_d, acknack_q, acknack_d;
  logic [8:0]       data_in_q, data_in_d;
  logic             last_q, last_d, issue;

  always_comb begin
    state_d = state_q;   prim_d = prim_q;
    addr_d = addr_q;     rnw_d = rnw_q;   len_d = len_q;   stop_d = stop_q;
    count_d = count_q;   bus_held_d = bus_held_q;
    seen_d = seen_q;     gap_d = gap_q;
    nack_d = nack_q;     early_d = early_q;
    rx_data_d = rx_data_q;
    rx_valid_d = rx_valid_q & ~rx_ready;
    tx_ready_d = 1'b0;
    start_d = 1'b0; rstart_d = 1'b0; pstop_d = 1'b0;
    datatx_d = 1'b0; datarx_d = 1'b0; acknack_d = 1'b0;
    data_in_d = data_in_q; last_d = 1'b0;
    cnt_inc = count_q + LEN_W'(1);
    fin = stop_q ? STOP : DONE;
    case (state_q)
      IDLE: if (cmd_valid && cmd_ready_q) begin
        addr_d = cmd_addr; rnw_d = cmd_rnw; len_d = cmd_len; stop_d = cmd_stop;
        count_d = '0; nack_d = 1'b0; early_d = 1'b0;
        state_d = START;
      end
      START: if (!phy_busy) begin
        rstart_d = bus_held_q;
        start_d  = ~bus_held_q;
      end
      HDR: if (!phy_busy) begin
        datatx_d  = 1'b1;
        data_in_d = {addr_q, rnw_q, 1'b1};
      end
      ACK: if (!phy_busy) acknack_d = 1'b1;
      WR: if (!phy_busy && tx_valid) begin
        tx_ready_d = 1'b1;
        datatx_d   = 1'b1;
        data_in_d  = {tx_data, ~^tx_data};
        last_d     = (cnt_inc == len_q);
        count_d    = cnt_inc;
      end
      // An unconsumed rx byte stalls here; the PHY keeps SCL held meanwhile.
      RD, RD_HOLD: begin
        if (rx_valid_q && !rx_ready) state_d = RD_HOLD;
        else if (!phy_busy)          datarx_d = 1'b1;
        else                         state_d = RD;
      end
      STOP: if (!phy_busy) pstop_d = 1'b1;
      DONE: begin
        bus_held_d = ~(stop_q | nack_q);
        state_d    = IDLE;
      end
      WAIT: begin
        if (phy_busy)     seen_d = 1'b1;
        else if (!seen_q) gap_d = gap_q + GAP_W'(1);
        if (!phy_busy && (seen_q || gap_q == GAP_W'(ISSUE_GAP - 1))) begin
          case (prim_q)
            START: state_d = HDR;
            HDR:   state_d = ACK;
            ACK: begin
              if (phy_acknack_rcvd) begin
                nack_d  = 1'b1;
                state_d = STOP;
              end else if (len_q == '0) state_d = fin;
              else                      state_d = rnw_q ? RD : WR;
            end
            WR: state_d = (count_q == len_q) ? fin : WR;
            RD: begin
              rx_data_d  = phy_data_out[8:1];
              rx_valid_d = 1'b1;
              count_d    = cnt_inc;
              if (!phy_data_out[0] && cnt_inc < len_q) begin
                early_d = 1'b1;
                state_d = fin;
              end else begin
                state_d = (cnt_inc == len_q) ? fin : RD;
              end
            end
            default: state_d = DONE;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
    issue = start_d | rstart_d | pstop_d | datatx_d | datarx_d | acknack_d;
    if (issue) begin
      state_d = WAIT;
      prim_d  = (state_q == RD_HOLD) ? RD : state_q;
      seen_d  = 1'b0;
      gap_d   = '0;
    end
    cmd_ready_d  = (state_d == IDLE);
    busy_d       = (state_d != IDLE);
    done_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;  prim_q <= IDLE;
      addr_q <= '0;     rnw_q <= 1'b0;  len_q <= '0;  stop_q <= 1'b0;
      count_q <= '0;    bus_held_q <= 1'b0;
      seen_q <= 1'b0;   gap_q <= '0;
      nack_q <= 1'b0;   early_q <= 1'b0;
      rx_data_q <= '0;  rx_valid_q <= 1'b0;  tx_ready_q <= 1'b0;
      cmd_ready_q <= 1'b0; busy_q <= 1'b0;   done_valid_q <= 1'b0;
      start_q <= 1'b0;  rstart_q <= 1'b0;    pstop_q <= 1'b0;
      datatx_q <= 1'b0; datarx_q <= 1'b0;    acknack_q <= 1'b0;
      data_in_q <= '0;  last_q <= 1'b0;
    end else begin
      state_q <= state_d;  prim_q <= prim_d;
      addr_q <= addr_d;    rnw_q <= rnw_d;  len_q <= len_d;  stop_q <= stop_d;
      count_q <= count_d;  bus_held_q <= bus_held_d;
      seen_q <= seen_d;    gap_q <= gap_d;
      nack_q <= nack_d;    early_q <= early_d;
      rx_data_q <= rx_data_d; rx_valid_q <= rx_valid_d; tx_ready_q <= tx_ready_d;
      cmd_ready_q <= cmd_ready_d; busy_q <= busy_d; done_valid_q <= done_valid_d;
      start_q <= start_d;  rstart_q <= rstart_d; pstop_q <= pstop_d;
      datatx_q <= datatx_d; datarx_q <= datarx_d; acknack_q <= acknack_d;
      data_in_q <= data_in_d; last_q <= last_d;
    end
  end

  assign cmd_ready          = cmd_ready_q;
  assign tx_ready           = tx_ready_q;
  assign rx_data            = rx_data_q;
  assign rx_valid           = rx_valid_q;
  assign done_valid         = done_valid_q;
  assign done_nack          = nack_q;
  assign done_early         = early_q;
  assign done_count         = count_q;
  assign busy               = busy_q;
  assign phy_start          = start_q;
  assign phy_repeated_start = rstart_q;
  assign phy_stop           = pstop_q;
  assign phy_datatx         = datatx_q;
  assign phy_datarx         = datarx_q;
  assign phy_acknack_noh    = acknack_q;
  assign phy_data_in        = data_in_q;
  assign phy_data_in_last   = last_q;
endmodule

// File: tb/tb_i3c_transfer_sequencer.sv
// Directed bench for i3c_transfer_sequencer: a small PHY model answers each pulse,
// a logger records the primitive stream, and hand-computed sequences are compared.
module tb_i3c_transfer_sequencer;
  localparam int LEN_W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             cmd_valid, cmd_ready, cmd_rnw, cmd_stop;
  logic [6:0]       cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic [7:0]       tx_data = 8'h00;
  logic             tx_valid = 1'b0;
  logic             tx_ready;
  logic [7:0]       rx_data;
  logic             rx_valid, rx_ready;
  logic             done_valid, done_nack, done_early, busy;
  logic [LEN_W-1:0] done_count;
  logic             phy_start, phy_repeated_start, phy_stop, phy_datatx, phy_datarx, phy_acknack_noh;
  logic [8:0]       phy_data_in;
  logic             phy_data_in_last;
  logic             phy_busy = 1'b0;
  logic [8:0]       phy_data_out = 9'h000;
  logic             phy_acknack_rcvd;

  i3c_transfer_sequencer #(.ISSUE_GAP(4), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_rnw(cmd_rnw),
    .cmd_len(cmd_len), .cmd_stop(cmd_stop),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .done_valid(done_valid), .done_nack(done_nack), .done_early(done_early),
    .done_count(done_count), .busy(busy),
    .phy_start(phy_start), .phy_repeated_start(phy_repeated_start), .phy_stop(phy_stop),
    .phy_datatx(phy_datatx), .phy_datarx(phy_datarx), .phy_acknack_noh(phy_acknack_noh),
    .phy_data_in(phy_data_in), .phy_data_in_last(phy_data_in_last),
    .phy_busy(phy_busy), .phy_data_out(phy_data_out), .phy_acknack_rcvd(phy_acknack_rcvd)
  );

  // Primitive kinds in the event log
  localparam int K_START = 1, K_RSTART = 2, K_STOP = 3, K_TX = 4, K_RX = 5, K_ACK = 6;

  int n_chk = 0, n_pass = 0;
  int ev_q[$], exp_q[$], rx_q[$], tx_src[$], rd_w[$];
  int d_seen = 0, d_nack = 0, d_early = 0, d_cnt = 0, tx_used = 0;
  int d_base, tx_base, bcnt = 0;
  logic tx_rdy_d1 = 1'b0;

  function automatic int ev(input int k, input int d, input int l);
    return (k << 10) | (l << 9) | d;
  endfunction

  function automatic int count_kind(input int k);
    int n = 0;
    foreach (ev_q[i]) if ((ev_q[i] >> 10) == k) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic chk_log(input string tag);
    chk({tag, ".n_prims"}, ev_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++)
      chk($sformatf("%s.prim%0d", tag, i), ev_q[i], exp_q[i]);
  endtask

  // PHY model: busy for three cycles after every pulse; read words come from rd_w
  always @(negedge clk) begin
    if (rst) bcnt = 0;
    else if (phy_start | phy_repeated_start | phy_stop | phy_datatx | phy_datarx | phy_acknack_noh) bcnt = 3;
    else if (bcnt > 0) bcnt--;
    phy_busy = (bcnt != 0);
    if (!rst && phy_datarx && rd_w.size() > 0) phy_data_out = 9'(rd_w.pop_front());
  end

  // Write-byte source: hold the head byte until the cycle after tx_ready
  always @(negedge clk) begin
    if (tx_rdy_d1 && tx_src.size() > 0) void'(tx_src.pop_front());
    if (tx_ready) tx_used++;
    tx_rdy_d1 = tx_ready;
    tx_valid  = (tx_src.size() > 0);
    tx_data   = (tx_src.size() > 0) ? 8'(tx_src[0]) : 8'h00;
  end

  always @(negedge clk) if (!rst) begin
    if (phy_start)          ev_q.push_back(ev(K_START, 0, 0));
    if (phy_repeated_start) ev_q.push_back(ev(K_RSTART, 0, 0));
    if (phy_stop)           ev_q.push_back(ev(K_STOP, 0, 0));
    if (phy_datatx)         ev_q.push_back(ev(K_TX, int'(phy_data_in), int'(phy_data_in_last)));
    if (phy_datarx)         ev_q.push_back(ev(K_RX, 0, 0));
    if (phy_acknack_noh)    ev_q.push_back(ev(K_ACK, 0, 0));
    if (rx_valid && rx_ready) rx_q.push_back(int'(rx_data));
    if (done_valid) begin
      d_seen++; d_nack = done_nack; d_early = done_early; d_cnt = done_count;
    end
  end

  function automatic int out_flags();
    return {cmd_ready, tx_ready, rx_valid, done_valid, done_nack, done_early, busy,
            phy_start, phy_repeated_start, phy_stop, phy_datatx, phy_datarx,
            phy_acknack_noh, phy_data_in_last};
  endfunction

  function automatic int out_data();
    return {rx_data, done_count, phy_data_in};
  endfunction

  task automatic issue_cmd(input int a, input int r, input int l, input int s);
    int t = 0;
    while (!cmd_ready && t < 200) begin @(negedge clk); t++; end
    chk("cmd_ready_wait", cmd_ready, 1);
    d_base = d_seen; tx_base = tx_used;
    cmd_valid = 1'b1; cmd_addr = 7'(a); cmd_rnw = 1'(r); cmd_len = LEN_W'(l); cmd_stop = 1'(s);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while (d_seen == d_base && t < 3000) begin @(negedge clk); t++; end
    chk({tag, ".done_pulse"}, d_seen - d_base, 1);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_rnw = 1'b0; cmd_len = '0; cmd_stop = 1'b0;
    rx_ready = 1'b1; phy_acknack_rcvd = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset.flags", out_flags(), 0);
    chk("reset.data", out_data(), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset.cmd_ready", cmd_ready, 1);

    // Write 0x50, two bytes, STOP. Header {0x50,0,1}=0x141; 0xA5 has even weight -> T=1 (0x14B);
    // 0x01 has odd weight -> T=0 (0x002), flagged last.
    ev_q.delete(); tx_src = '{'hA5, 'h01};
    issue_cmd('h50, 0, 2, 1);
    wait_done("wr");
    exp_q = '{ev(K_START,0,0), ev(K_TX,'h141,0), ev(K_ACK,0,0), ev(K_TX,'h14B,0),
              ev(K_TX,'h002,1), ev(K_STOP,0,0)};
    chk_log("wr");
    chk("wr.count", d_cnt, 2);
    chk("wr.nack", d_nack, 0);
    chk("wr.early", d_early, 0);
    chk("wr.tx_used", tx_used - tx_base, 2);

    // Read 0x12, three bytes, consumer stalls 20 cycles after the first byte
    ev_q.delete(); rx_q.delete(); rx_ready = 1'b0;
    rd_w = '{'h079, 'h0B5, 'h187};
    issue_cmd('h12, 1, 3, 1);
    t = 0;
    while (!rx_valid && t < 500) begin @(negedge clk); t++; end
    chk("rd.first_byte", rx_valid, 1);
    repeat (20) @(negedge clk);
    chk("rd.stall_datarx", count_kind(K_RX), 1);
    chk("rd.stall_valid", rx_valid, 1);
    chk("rd.stall_data", rx_data, 'h3C);
    rx_ready = 1'b1;
    wait_done("rd");
    exp_q = '{ev(K_START,0,0), ev(K_TX,'h04B,0), ev(K_ACK,0,0), ev(K_RX,0,0),
              ev(K_RX,0,0), ev(K_RX,0,0), ev(K_STOP,0,0)};
    chk_log("rd");
    chk("rd.n_bytes", rx_q.size(), 3);
    if (rx_q.size() == 3) begin
      chk("rd.byte0", rx_q[0], 'h3C);
      chk("rd.byte1", rx_q[1], 'h5A);
      chk("rd.byte2", rx_q[2], 'hC3);
    end
    chk("rd.count", d_cnt, 3);

    // Header NACK with hold requested: STOP still goes out, no byte consumed
    ev_q.delete(); phy_acknack_rcvd = 1'b1; tx_src = '{'h77, 'h88};
    issue_cmd('h33, 0, 2, 0);
    wait_done("nack");
    exp_q = '{ev(K_START,0,0), ev(K_TX,'h0CD,0), ev(K_ACK,0,0), ev(K_STOP,0,0)};
    chk_log("nack");
    chk("nack.nack", d_nack, 1);
    chk("nack.count", d_cnt, 0);
    chk("nack.tx_used", tx_used - tx_base, 0);
    phy_acknack_rcvd = 1'b0; tx_src.delete();
    repeat (2) @(negedge clk);

    // Held bus: write without STOP, then a read must open with a repeated start
    ev_q.delete(); rx_q.delete(); tx_src = '{'hFF}; rd_w = '{'h101};
    issue_cmd('h0A, 0, 1, 0);
    wait_done("hold1");
    chk("hold1.count", d_cnt, 1);
    issue_cmd('h0B, 1, 1, 1);
    wait_done("hold2");
    exp_q = '{ev(K_START,0,0), ev(K_TX,'h029,0), ev(K_ACK,0,0), ev(K_TX,'h1FF,1),
              ev(K_RSTART,0,0), ev(K_TX,'h02F,0), ev(K_ACK,0,0), ev(K_RX,0,0), ev(K_STOP,0,0)};
    chk_log("hold");
    chk("hold2.byte", (rx_q.size() > 0) ? rx_q[0] : -1, 'h80);

    // Target ends a four-byte read after the second byte
    ev_q.delete(); rx_q.delete(); rd_w = '{'h023, 'h044};
    issue_cmd('h21, 1, 4, 1);
    wait_done("early");
    exp_q = '{ev(K_START,0,0), ev(K_TX,'h087,0), ev(K_ACK,0,0), ev(K_RX,0,0),
              ev(K_RX,0,0), ev(K_STOP,0,0)};
    chk_log("early");
    chk("early.early", d_early, 1);
    chk("early.count", d_cnt, 2);
    chk("early.nack", d_nack, 0);
    chk("early.n_bytes", rx_q.size(), 2);

    // Reset while WR waits for a second byte that never arrives
    ev_q.delete(); tx_src = '{'h0F};
    issue_cmd('h40, 0, 3, 1);
    t = 0;
    while (tx_used == tx_base && t < 500) begin @(negedge clk); t++; end
    chk("rstwr.first_byte", tx_used - tx_base, 1);
    repeat (15) @(negedge clk);
    d_base = d_seen;
    rst = 1'b1;
    @(negedge clk);
    chk("rstwr.flags", out_flags(), 0);
    chk("rstwr.data", out_data(), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstwr.cmd_ready", cmd_ready, 1);
    repeat (10) @(negedge clk);
    exp_q = '{ev(K_START,0,0), ev(K_TX,'h101,0), ev(K_ACK,0,0), ev(K_TX,'h01F,0)};
    chk_log("rstwr");
    chk("rstwr.no_done", d_seen - d_base, 0);
    chk("rstwr.idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
